// File: rtl/adder_rr_arbiter_pkg.sv
// Shared definitions for the adder round-robin arbiter slice.
// Optional build macro: ADDER_ARB_FIXED_PRI_EN (fixed lowest-index priority).
package adder_rr_arbiter_pkg;

    localparam int OPW   = 4;   // operand / sum width
    localparam int CNT_W = 8;   // accepted-request counter width

    // Output buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Request/response bus between the operand sources, the arbiter and the consumer.
// Handshake: a beat moves on a rising clk edge where valid & ready are both 1;
// valid must not wait on ready, ready may depend on valid, and an un-transferred
// valid may be withdrawn (no transfer happens for it).
interface adder_rr_arbiter_if
    import adder_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [OPW*NUM_REQ-1:0] req_a;
    logic [OPW*NUM_REQ-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [OPW-1:0]         rsp_s;
    logic                   rsp_c;
    logic [ID_W-1:0]        rsp_id;
    logic [CNT_W-1:0]       grant_cnt;

    // Requesters and response consumer
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_c, rsp_id, grant_cnt
    );

    // Arbiter
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_c, rsp_id, grant_cnt
    );
endinterface

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational one-hot round-robin picker: first valid at index >= rr_ptr,
// searching modulo NUM_REQ. With rr_ptr held at 0 it is a fixed-priority picker.
module adder_rr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PW-1:0]      rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx
);
    logic          found;
    logic [PW-1:0] pos;

    // Rotate the search start to rr_ptr and take the first valid requester
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (en && !found && req_valid[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end
endmodule

// File: rtl/four_adder.sv
// Plain 4-bit adder with carry-out; the single shared datapath.
module four_adder
    import adder_rr_arbiter_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] s,
    output logic           c
);
    assign {c, s} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one four_adder among NUM_REQ requesters. One grant per clock, result
// registered into a 1-entry buffer and returned tagged with the requester id.
// Optional build macro: ADDER_ARB_FIXED_PRI_EN (lowest index wins, no rr pointer).
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_rr_arbiter_if.slave  bus,
    output buf_state_e         state_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    buf_state_e         state_q, state_d;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_ok;
    logic               accept;
    logic [OPW-1:0]     op_a, op_b, sum_s;
    logic               sum_c;
    logic [OPW-1:0]     s_q;
    logic               c_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;

    // A new grant is possible when the buffer is empty or is being drained now.
    // Gated by rst_n so nothing is offered while reset is held.
    assign grant_ok = ((state_q == ST_EMPTY) || bus.rsp_ready) && rst_n;

    adder_rr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .en        (grant_ok),
        .gnt       (gnt),
        .idx       (gnt_idx)
    );

    // gnt is only non-zero for a valid requester, so any grant is a transfer
    assign accept        = |gnt;
    assign bus.req_ready = gnt;

    // One-hot AND-OR operand mux driven by the grant
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                op_a = bus.req_a[k*OPW +: OPW];
                op_b = bus.req_b[k*OPW +: OPW];
            end
        end
    end

    four_adder u_add (
        .a (op_a),
        .b (op_b),
        .s (sum_s),
        .c (sum_c)
    );

`ifdef ADDER_ARB_FIXED_PRI_EN
    assign rr_ptr = '0;
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer moves to the slot just after the winner, only on an accept
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // Buffer occupancy next-state: fill on accept, empty only on drain without refill
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Buffer occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Result buffer and accept counter; overwritten on every accept, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            c_q   <= 1'b0;
            id_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            s_q   <= sum_s;
            c_q   <= sum_c;
            id_q  <= ID_W'(gnt_idx);
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_s     = s_q;
    assign bus.rsp_c     = c_q;
    assign bus.rsp_id    = id_q;
    assign bus.grant_cnt = cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: reference model of the arbitration rules plus
// a response scoreboard. Honours ADDER_ARB_FIXED_PRI_EN when defined.
module tb_adder_rr_arbiter;
    import adder_rr_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int RW      = ID_W + 5;   // {id, carry, sum}
    localparam int IW      = 2;          // index width for NUM_REQ=4

    logic       clk = 1'b0;
    logic       rst_n;
    buf_state_e dbg_state;

    adder_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    adder_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    logic [RW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;

    int            m_ptr  = 0;      // next search start
    int            m_cnt  = 0;      // accepted requests mod 256
    bit            m_full = 1'b0;   // result waiting at the output
    bit            pend_acc = 1'b0;
    bit            pend_rdy = 1'b0;
    int            pend_idx = 0;
    logic [RW-1:0] pend_entry = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Apply the transfer decided last cycle at the edge where the DUT captures it
    task automatic commit();
        if (pend_acc) begin
            exp_q.push_back(pend_entry);
            m_cnt = (m_cnt + 1) % 256;
`ifndef ADDER_ARB_FIXED_PRI_EN
            m_ptr = (pend_idx + 1) % NUM_REQ;
`endif
        end
        m_full   = pend_acc ? 1'b1 : (pend_rdy ? 1'b0 : m_full);
        pend_acc = 1'b0;
        pend_rdy = 1'b0;
    endtask

    // Decide the expected grant for the inputs currently applied and check it
    task automatic predict();
        logic [NUM_REQ-1:0] eg;
        int                 gi;
        int                 an;
        int                 bn;
        logic [IW-1:0]      jj;
        eg = '0;
        gi = -1;
        if (!m_full || bus.rsp_ready) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                jj = IW'((m_ptr + k) % NUM_REQ);
                if (gi < 0 && bus.req_valid[jj]) gi = int'(jj);
            end
        end
        if (gi >= 0) begin
            eg = NUM_REQ'(1) << gi;
            an = int'(bus.req_a >> (4 * gi)) & 15;
            bn = int'(bus.req_b >> (4 * gi)) & 15;
            pend_entry = RW'(gi * 32 + an + bn);
        end
        check("req_ready", 32'(bus.req_ready), 32'(eg));
        check("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
        pend_acc = (gi >= 0);
        pend_idx = gi;
        pend_rdy = bus.rsp_ready;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic [NUM_REQ-1:0] v, input logic [4*NUM_REQ-1:0] a,
                         input logic [4*NUM_REQ-1:0] b, input logic rr);
        @(posedge clk);
        commit();
        #1;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rr;
        @(negedge clk);
        predict();
    endtask

    task automatic rand_cycle(input logic [NUM_REQ-1:0] v, input logic rr);
        cycle(v, 16'($urandom), 16'($urandom), rr);
    endtask

    // Asserts reset from the current (post-negedge) point, checks it, then releases
    task automatic do_reset();
        #1;
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_grant_cnt", 32'(bus.grant_cnt), 0);
        exp_q.delete();
        m_ptr = 0; m_cnt = 0; m_full = 1'b0;
        pend_acc = 1'b0; pend_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_hold_req_ready", 32'(bus.req_ready), 0);
        check("rst_hold_rsp_valid", 32'(bus.rsp_valid), 0);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
                if (bus.rsp_valid && exp_q.size() != 0) begin
                    check("rsp_data", 32'({bus.rsp_id, bus.rsp_c, bus.rsp_s}), 32'(exp_q[0]));
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset held with every requester asking
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #2;
        check("init_req_ready", 32'(bus.req_ready), 0);
        check("init_rsp_valid", 32'(bus.rsp_valid), 0);
        check("init_grant_cnt", 32'(bus.grant_cnt), 0);
        repeat (3) @(posedge clk);
        #2;
        check("init_hold_req_ready", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single requester: 8+9 -> s=1 c=1, then 15+0 -> s=15 c=0
        cycle(4'b0001, 16'h0008, 16'h0009, 1'b1);
        cycle(4'b0001, 16'h000F, 16'h0000, 1'b1);
        check("single_s", 32'(bus.rsp_s), 1);
        check("single_c", 32'(bus.rsp_c), 1);
        check("single_id", 32'(bus.rsp_id), 0);
        cycle(4'b0000, 16'h0000, 16'h0000, 1'b1);
        check("single2_s", 32'(bus.rsp_s), 15);
        check("single2_c", 32'(bus.rsp_c), 0);
        cycle(4'b0000, 16'h0000, 16'h0000, 1'b1);

        // all four asking, sink always ready
        repeat (8) rand_cycle(4'b1111, 1'b1);

        // backpressure: fill, stall 3 cycles, then release with a same-cycle grant
        rand_cycle(4'b1111, 1'b1);
        repeat (3) rand_cycle(4'b1111, 1'b0);
        rand_cycle(4'b1111, 1'b1);

        // drain and accept together: 7+9 from requester 2 -> s=0 c=1 id=2
        rand_cycle(4'b1111, 1'b1);
        cycle(4'b0100, 16'h0700, 16'h0900, 1'b1);
        cycle(4'b0000, 16'h0000, 16'h0000, 1'b0);
        check("pass_valid", 32'(bus.rsp_valid), 1);
        check("pass_s", 32'(bus.rsp_s), 0);
        check("pass_c", 32'(bus.rsp_c), 1);
        check("pass_id", 32'(bus.rsp_id), 2);
        cycle(4'b0000, 16'h0000, 16'h0000, 1'b1);

        // random traffic with random withdrawal and backpressure
        repeat (300) rand_cycle(NUM_REQ'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));

        // counter wrap: exactly 256 accepts from a fresh reset
        do_reset();
        repeat (256) rand_cycle(4'b1111, 1'b1);
        cycle(4'b0000, 16'h0000, 16'h0000, 1'b1);
        check("grant_cnt_wrap", 32'(bus.grant_cnt), 0);

        // reset while a result is held: it must vanish and never reappear
        rand_cycle(4'b1111, 1'b0);
        rand_cycle(4'b0000, 1'b0);
        check("full_before_reset", 32'(bus.rsp_valid), 1);
        do_reset();
        repeat (4) cycle(4'b0000, 16'h0000, 16'h0000, 1'b1);

        // short random burst after reset, then drain
        repeat (40) rand_cycle(NUM_REQ'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0));
        repeat (4) cycle(4'b0000, 16'h0000, 16'h0000, 1'b1);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
